// File: rtl/datapath_seq_pkg.sv
// Shared encodings for the sequenced datapath: FSM states and the
// command field encodings for ALU op, B-operand shift and write-back source.
package datapath_seq_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      EXEC = 3'd2,
      WB   = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_AND  = 2'b10,
      ALU_NOTB = 2'b11
   } aluop_t;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_t;

   typedef enum logic [1:0] {
      WB_C     = 2'b00,
      WB_IMM   = 2'b01,
      WB_MDATA = 2'b10,
      WB_PC    = 2'b11
   } wsel_t;

endpackage

// File: rtl/datapath_seq_regfile.sv
// Register file: one synchronous write port, two combinational read ports,
// every entry cleared by the asynchronous reset.
module regfile_p #(
   parameter  int WIDTH = 16,
   parameter  int NREG  = 8,
   localparam int RW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [RW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [RW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [RW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [NREG];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle datapath: accepts one command in IDLE, then walks
// LOAD -> EXEC -> WB -> DONE, reading two registers, running the ALU and writing back.
module datapath_seq
   import datapath_seq_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int NREG  = 8,
   parameter  int PCW   = 9,
   localparam int RW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [RW-1:0]    cmd_rn,
   input  logic [RW-1:0]    cmd_rm,
   input  logic [RW-1:0]    cmd_rd,
   input  logic [1:0]       cmd_shift,
   input  logic [1:0]       cmd_aluop,
   input  logic             cmd_azero,
   input  logic             cmd_bimm,
   input  logic [WIDTH-1:0] cmd_imm,
   input  logic [1:0]       cmd_wsel,
   input  logic             cmd_wen,
   input  logic             cmd_setf,
   input  logic [WIDTH-1:0] mdata,
   input  logic [PCW-1:0]   pc,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             Z,
   output logic             N,
   output logic             V
);

   localparam int MSB = WIDTH - 1;

   state_t state, state_nxt;

   logic [RW-1:0]    rn_q, rm_q, rd_q;
   shift_t           shift_q;
   aluop_t           aluop_q;
   wsel_t            wsel_q;
   logic             azero_q, bimm_q, wen_q, setf_q;
   logic [WIDTH-1:0] imm_q;

   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic [WIDTH-1:0] rdata_a, rdata_b;
   logic [WIDTH-1:0] a_in, b_s, b_in, sum, diff, alu_y, wb_data;
   logic             alu_v;
   logic             accept;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = LOAD;
         end
         LOAD: state_nxt = EXEC;
         EXEC: state_nxt = WB;
         WB:   state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = cmd_ready && cmd_valid;

   // Command fields are captured once so the inputs are free to change mid-command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rn_q    <= '0;
         rm_q    <= '0;
         rd_q    <= '0;
         shift_q <= SH_NONE;
         aluop_q <= ALU_ADD;
         wsel_q  <= WB_C;
         azero_q <= 1'b0;
         bimm_q  <= 1'b0;
         wen_q   <= 1'b0;
         setf_q  <= 1'b0;
         imm_q   <= '0;
      end else if (accept) begin
         rn_q    <= cmd_rn;
         rm_q    <= cmd_rm;
         rd_q    <= cmd_rd;
         shift_q <= shift_t'(cmd_shift);
         aluop_q <= aluop_t'(cmd_aluop);
         wsel_q  <= wsel_t'(cmd_wsel);
         azero_q <= cmd_azero;
         bimm_q  <= cmd_bimm;
         wen_q   <= cmd_wen;
         setf_q  <= cmd_setf;
         imm_q   <= cmd_imm;
      end
   end

   // ---------------- operand path and ALU ----------------
   always_comb begin
      a_in = azero_q ? '0 : a_q;
      b_s  = b_q;
      unique case (shift_q)
         SH_NONE: b_s = b_q;
         SH_LSL1: b_s = {b_q[MSB-1:0], 1'b0};
         SH_LSR1: b_s = {1'b0, b_q[MSB:1]};
         SH_ASR1: b_s = {b_q[MSB], b_q[MSB:1]};
         default: b_s = b_q;
      endcase
      b_in = bimm_q ? imm_q : b_s;
      sum  = a_in + b_in;
      diff = a_in - b_in;
   end

   always_comb begin
      alu_y = sum;
      alu_v = 1'b0;
      unique case (aluop_q)
         ALU_ADD: begin
            alu_y = sum;
            alu_v = (a_in[MSB] == b_in[MSB]) && (sum[MSB] != a_in[MSB]);
         end
         ALU_SUB: begin
            alu_y = diff;
            alu_v = (a_in[MSB] != b_in[MSB]) && (diff[MSB] != a_in[MSB]);
         end
         ALU_AND:  alu_y = a_in & b_in;
         ALU_NOTB: alu_y = ~b_in;
         default: begin
            alu_y = sum;
            alu_v = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         Z   <= 1'b0;
         N   <= 1'b0;
         V   <= 1'b0;
      end else begin
         if (state == LOAD) begin
            a_q <= rdata_a;
            b_q <= rdata_b;
         end
         if (state == EXEC) begin
            c_q <= alu_y;
            if (setf_q) begin
               Z <= (alu_y == '0);
               N <= alu_y[MSB];
               V <= alu_v;
            end
         end
      end
   end

   assign result = c_q;

   // ---------------- write-back ----------------
   always_comb begin
      wb_data = c_q;
      unique case (wsel_q)
         WB_C:     wb_data = c_q;
         WB_IMM:   wb_data = imm_q;
         WB_MDATA: wb_data = mdata;
         WB_PC:    wb_data = WIDTH'(pc);
         default:  wb_data = c_q;
      endcase
   end

   regfile_p #(.WIDTH(WIDTH), .NREG(NREG)) u_rf (
      .clk     (clk),
      .reset   (reset),
      .we      ((state == WB) && wen_q),
      .waddr   (rd_q),
      .wdata   (wb_data),
      .raddr_a (rn_q),
      .rdata_a (rdata_a),
      .raddr_b (rm_q),
      .rdata_b (rdata_b)
   );

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: register contents are observed through the
// command interface by adding zero to a register and reading result.
module tb_datapath_seq;

   localparam int WIDTH = 16;
   localparam int NREG  = 8;
   localparam int PCW   = 9;
   localparam int RW    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [RW-1:0]    cmd_rn, cmd_rm, cmd_rd;
   logic [1:0]       cmd_shift, cmd_aluop, cmd_wsel;
   logic             cmd_azero, cmd_bimm, cmd_wen, cmd_setf;
   logic [WIDTH-1:0] cmd_imm;
   logic [WIDTH-1:0] mdata;
   logic [PCW-1:0]   pc;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             Z, N, V;

   int n_tests = 0;
   int n_fail  = 0;

   datapath_seq #(.WIDTH(WIDTH), .NREG(NREG), .PCW(PCW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
      .cmd_shift(cmd_shift), .cmd_aluop(cmd_aluop),
      .cmd_azero(cmd_azero), .cmd_bimm(cmd_bimm), .cmd_imm(cmd_imm),
      .cmd_wsel(cmd_wsel), .cmd_wen(cmd_wen), .cmd_setf(cmd_setf),
      .mdata(mdata), .pc(pc), .done(done), .result(result),
      .Z(Z), .N(N), .V(V)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_cmd(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [2:0] rd, input logic [1:0] sh, input logic [1:0] wsel,
                          input logic az, input logic bi, input logic wen, input logic setf,
                          input logic [15:0] imm);
      cmd_aluop = op;  cmd_rn = rn;   cmd_rm = rm;     cmd_rd = rd;
      cmd_shift = sh;  cmd_wsel = wsel; cmd_azero = az; cmd_bimm = bi;
      cmd_wen = wen;   cmd_setf = setf; cmd_imm = imm;
   endtask

   // Called at a negedge; returns cycles from the acceptance edge to done.
   task automatic issue(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                        input logic [2:0] rd, input logic [1:0] sh, input logic [1:0] wsel,
                        input logic az, input logic bi, input logic wen, input logic setf,
                        input logic [15:0] imm, output int lat);
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
      set_cmd(op, rn, rm, rd, sh, wsel, az, bi, wen, setf, imm);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      set_cmd(2'b11, 3'd7, 3'd7, 3'd7, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 16'hDEAD);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!done) chk("done_timeout", 32'(lat), 32'd4);
   endtask

   task automatic wr(input logic [2:0] r, input logic [15:0] v);
      int l;
      issue(2'b00, 3'd0, 3'd0, r, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, v, l);
   endtask

   task automatic rdr(input logic [2:0] r, output logic [15:0] v);
      int l;
      issue(2'b00, r, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, l);
      v = result;
   endtask

   task automatic alu(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                      input logic [2:0] rd, input logic [1:0] sh, input logic bi,
                      input logic [15:0] imm, input logic az, input logic wen, input logic setf);
      int l;
      issue(op, rn, rm, rd, sh, 2'b00, az, bi, wen, setf, imm, l);
   endtask

   initial begin
      logic [15:0] v;
      int          lat;
      logic [19:0] rdy_obs, dn_obs;
      int          acc;
      logic        saw_done;

      reset = 1'b1;
      cmd_valid = 1'b0;
      set_cmd(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      mdata = 16'hBEEF;
      pc    = 9'h1A5;
      @(negedge clk);
      chk("rst_done_during", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'h0000);
      chk("rst_flags", {29'd0, Z, N, V}, 32'd0);

      // immediate write to R0 and its latency
      issue(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, lat);
      chk("imm_latency", 32'(lat), 32'd4);
      rdr(3'd0, v);
      chk("imm_r0", 32'(v), 32'h0007);

      // signed overflow on ADD
      wr(3'd1, 16'h7FFF);
      wr(3'd2, 16'h0001);
      alu(2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      chk("add_result", 32'(result), 32'h8000);
      chk("add_znv", {29'd0, Z, N, V}, 32'b010 | 32'b001);
      rdr(3'd3, v);
      chk("add_r3", 32'(v), 32'h8000);

      // SUB sets Z, AND with setf=0 keeps it
      wr(3'd1, 16'h0005);
      wr(3'd2, 16'h0005);
      alu(2'b01, 3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("sub_result", 32'(result), 32'h0000);
      chk("sub_znv", {29'd0, Z, N, V}, 32'b100);
      alu(2'b10, 3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("and_result", 32'(result), 32'h0005);
      chk("and_z_hold", 32'(Z), 32'd1);

      // shifts through NOT-B
      wr(3'd2, 16'h8004);
      alu(2'b11, 3'd0, 3'd2, 3'd0, 2'b11, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("asr_notb", 32'(result), 32'h3FFD);
      chk("notb_znv", {29'd0, Z, N, V}, 32'b000);
      alu(2'b11, 3'd0, 3'd2, 3'd0, 2'b10, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("lsr_notb", 32'(result), 32'hBFFD);
      alu(2'b11, 3'd0, 3'd2, 3'd0, 2'b01, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("lsl_notb", 32'(result), 32'hFFF7);

      // signed overflow on SUB
      wr(3'd1, 16'h8000);
      wr(3'd2, 16'h0001);
      alu(2'b01, 3'd1, 3'd2, 3'd0, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("sub_ovf_result", 32'(result), 32'h7FFF);
      chk("sub_ovf_znv", {29'd0, Z, N, V}, 32'b001);

      // azero with immediate B
      alu(2'b00, 3'd1, 3'd0, 3'd0, 2'b00, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
      chk("azero_imm", 32'(result), 32'h1234);

      // write-back sources pc, mdata, and wen=0
      issue(2'b00, 3'd0, 3'd0, 3'd5, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, lat);
      rdr(3'd5, v);
      chk("wb_pc", 32'(v), 32'h01A5);
      issue(2'b00, 3'd0, 3'd0, 3'd6, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, lat);
      rdr(3'd6, v);
      chk("wb_mdata", 32'(v), 32'hBEEF);
      issue(2'b00, 3'd0, 3'd0, 3'd5, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4444, lat);
      rdr(3'd5, v);
      chk("wen0_hold", 32'(v), 32'h01A5);

      // rd == rn: each write visible to the next command
      wr(3'd6, 16'h000A);
      alu(2'b00, 3'd6, 3'd0, 3'd6, 2'b00, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      alu(2'b00, 3'd6, 3'd0, 3'd6, 2'b00, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
      rdr(3'd6, v);
      chk("rd_eq_rn", 32'(v), 32'h000C);

      // back-to-back: valid held high for 12 cycles
      while (!cmd_ready) @(negedge clk);
      set_cmd(2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         rdy_obs[i] = cmd_ready;
         dn_obs[i]  = done;
         cmd_valid  = (i < 12);
         if (cmd_valid && cmd_ready) acc++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_ready_pat", 32'(rdy_obs), 32'hF8421);
      chk("b2b_done_pat", 32'(dn_obs), 32'h04210);

      // reset during EXEC of a write to R4
      wr(3'd7, 16'h5A5A);
      wr(3'd4, 16'h00FF);
      set_cmd(2'b00, 3'd0, 3'd0, 3'd4, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1234);
      while (!cmd_ready) @(negedge clk);
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_ready_in_rst", 32'(cmd_ready), 32'd1);
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 1) reset = 1'b0;
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'd0);
      chk("abort_ready", 32'(cmd_ready), 32'd1);
      rdr(3'd4, v);
      chk("abort_r4", 32'(v), 32'h0000);
      rdr(3'd7, v);
      chk("abort_r7", 32'(v), 32'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
